// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg
// Shared definitions for the bit-serial ALU sequencer.
//   state_t        : sequencer states (IDLE, RUN, DONE)
//   ALU_CTRL_*     : canonical 4-bit alu_ctrl codes {a_invert, b_invert, op[1:0]}
//   OP_*           : 2-bit slice operation encodings
// Optional feature macro used by the sequencer: SERIAL_ALU_OVF_EN.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
  localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

endpackage

// File: rtl/serial_slice.sv
// serial_slice
// Combinational 1-bit ALU slice.
// Ports:
//   a, b                 : operand bits
//   less                 : bit driven onto the result for OP_SLT
//   a_invert, b_invert   : per-operand inversion
//   carry_in             : carry into this bit
//   op                   : OP_AND / OP_OR / OP_ADD / OP_SLT
//   result               : selected slice output
//   carry_out            : majority carry out of this bit
//   sum                  : raw adder sum (used for SLT set and overflow)
module serial_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       carry_in,
  input  logic [1:0] op,
  output logic       result,
  output logic       carry_out,
  output logic       sum
);

  logic ai;
  logic bi;

  assign ai        = a ^ a_invert;
  assign bi        = b ^ b_invert;
  assign sum       = ai ^ bi ^ carry_in;
  assign carry_out = (ai & bi) | (ai & carry_in) | (bi & carry_in);

  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = ai & bi;
      OP_OR:   result = ai | bi;
      OP_ADD:  result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq
// Bit-serial ALU sequencer: one WIDTH-bit operation streamed LSB-first through
// a single serial_slice, one bit per clock, with valid/ready on both sides.
// Optional feature macro: SERIAL_ALU_OVF_EN (adds the overflow port and flop).
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   start_valid / start_ready : request handshake (ready only in IDLE)
//   a, b, alu_ctrl            : operands and {a_invert, b_invert, op}, sampled on accept
//   done_valid / done_ready   : result handshake
//   result, zero, carry_out   : result word and flags, stable in DONE
//   overflow                  : signed overflow (SERIAL_ALU_OVF_EN only)
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [3:0]         ctrl_q;
  logic               carry_q;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;
  logic               cout_q;
  logic               dv_q;

  logic               accept;
  logic               last_bit;
  logic               handshake;
  logic               slice_res;
  logic               slice_cout;
  logic               slice_sum;
  logic               ovf;
  logic               set;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   final_res;

  assign start_ready = (state == S_IDLE);
  assign accept      = start_ready & start_valid;
  assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
  assign handshake   = dv_q & done_ready;

  serial_slice u_slice (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .less      (1'b0),
    .a_invert  (ctrl_q[3]),
    .b_invert  (ctrl_q[2]),
    .carry_in  (carry_q),
    .op        (ctrl_q[1:0]),
    .result    (slice_res),
    .carry_out (slice_cout),
    .sum       (slice_sum)
  );

  // At the MSB, carry_q is the carry into the MSB and slice_cout the carry out.
  assign ovf     = carry_q ^ slice_cout;
  assign set     = slice_sum ^ ovf;
  assign shifted = {slice_res, res_q[WIDTH-1:1]};

  always_comb begin
    final_res = shifted;
    if (ctrl_q[1:0] == OP_SLT) final_res[0] = set;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_valid) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  if (handshake) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // done_valid trails entry into DONE by one edge: that edge is the
  // registration step that makes the latency WIDTH+1 from accept.
  always_ff @(posedge clk) begin
    if (!rst_n) dv_q <= 1'b0;
    else        dv_q <= (state == S_DONE) & ~handshake;
  end

  // Operand shift registers carry no reset: they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      ctrl_q <= alu_ctrl;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      carry_q <= alu_ctrl[2];
    end else if (state == S_RUN) begin
      cnt     <= cnt + CNT_W'(1);
      carry_q <= slice_cout;
      if (last_bit) begin
        res_q  <= final_res;
        zero_q <= (final_res == '0);
        cout_q <= slice_cout;
      end else begin
        res_q  <= shifted;
      end
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                          ovf_q <= 1'b0;
    else if ((state == S_RUN) && last_bit) ovf_q <= ovf;
  end

  assign overflow = ovf_q;
`endif

  assign done_valid = dv_q;
  assign result     = res_q;
  assign zero       = zero_q;
  assign carry_out  = cout_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq
// Self-checking bench for serial_alu_seq (WIDTH=32): directed cases, backpressure,
// mid-run reset and randomized operations compared against an arithmetic model.
// Honors SERIAL_ALU_OVF_EN the same way as the design.
module tb_serial_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_ctrl;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry_out;
`ifdef SERIAL_ALU_OVF_EN
  logic         overflow;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .alu_ctrl    (alu_ctrl),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .result      (result),
    .zero        (zero),
    .carry_out   (carry_out)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .overflow    (overflow)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: invert operands, add with carry-in = b_invert,
  // pick the logical/arithmetic result, and derive SLT from sign ^ overflow.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic [3:0] mc, output logic [W-1:0] r,
                                output logic z, output logic co, output logic ov);
    logic [W-1:0] ai;
    logic [W-1:0] bi;
    logic [W:0]   s;
    ai = mc[3] ? ~ma : ma;
    bi = mc[2] ? ~mb : mb;
    s  = {1'b0, ai} + {1'b0, bi} + (W+1)'(mc[2]);
    co = s[W];
    ov = (ai[W-1] == bi[W-1]) && (s[W-1] != ai[W-1]);
    case (mc[1:0])
      2'b00:   r = ai & bi;
      2'b01:   r = ai | bi;
      2'b10:   r = s[W-1:0];
      default: r = W'(s[W-1] ^ ov);
    endcase
    z = (r == '0);
  endfunction

  // Accept one request, scramble the inputs afterwards, wait for done_valid.
  task automatic launch(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [3:0] tc);
    int lat;
    @(negedge clk);
    a = ta; b = tb; alu_ctrl = tc; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a = $urandom; b = $urandom; alu_ctrl = 4'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done_valid && lat < 200);
    check({tag, "_latency"}, 64'(lat), 64'(W + 1));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic [3:0] tc);
    logic [W-1:0] er;
    logic ez, eco, eov;
    model(ta, tb, tc, er, ez, eco, eov);
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_zero"}, 64'(zero), 64'(ez));
    check({tag, "_cout"}, 64'(carry_out), 64'(eco));
`ifdef SERIAL_ALU_OVF_EN
    check({tag, "_ovf"}, 64'(overflow), 64'(eov));
`else
    eov = 1'b0;
`endif
  endtask

  task automatic handshake(input string tag);
    logic [W-1:0] held;
    held = result;
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    check({tag, "_dv_drop"}, 64'(done_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(start_ready), 64'd1);
    check({tag, "_res_kept"}, 64'(result), 64'(held));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [3:0] tc);
    launch(tag, ta, tb, tc);
    check_result(tag, ta, tb, tc);
    handshake(tag);
  endtask

  initial begin
    logic [W-1:0] held_res;
    logic         held_zero;
    logic         held_cout;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rc;

    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; alu_ctrl = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_cout", 64'(carry_out), 64'd0);
`ifdef SERIAL_ALU_OVF_EN
    check("rst_ovf", 64'(overflow), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    launch("add", 32'h5, 32'h3, 4'b0010);
    check("add_const", 64'(result), 64'h8);
    check_result("add", 32'h5, 32'h3, 4'b0010);
    handshake("add");

    launch("sub", 32'h7, 32'h7, 4'b0110);
    check("sub_const", 64'(result), 64'h0);
    check("sub_zero_const", 64'(zero), 64'd1);
    check("sub_cout_const", 64'(carry_out), 64'd1);
    handshake("sub");

    launch("slt_neg", 32'hFFFF_FFFF, 32'h1, 4'b0111);
    check("slt_neg_const", 64'(result), 64'h1);
    handshake("slt_neg");

    launch("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, 4'b0111);
    check("slt_ovf_const", 64'(result), 64'h0);
    check_result("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000, 4'b0111);
    handshake("slt_ovf");

    run_op("nor", 32'hF0F0_F0F0, 32'h0F0F_0F00, 4'b1100);
    run_op("or", 32'h0000_1000, 32'h8000_0001, 4'b0001);
    run_op("and_all", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000);

    // Backpressure: sit in DONE with new requests offered
    launch("bp", 32'h1234_5678, 32'h1111_1111, 4'b0010);
    held_res = result; held_zero = zero; held_cout = carry_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      a = $urandom; b = $urandom; alu_ctrl = 4'b0110;
      @(posedge clk);
      #1;
      check("bp_res_stable", 64'(result), 64'(held_res));
      check("bp_zero_stable", 64'(zero), 64'(held_zero));
      check("bp_cout_stable", 64'(carry_out), 64'(held_cout));
      check("bp_start_ready", 64'(start_ready), 64'd0);
      check("bp_done_valid", 64'(done_valid), 64'd1);
    end
    @(negedge clk);
    start_valid = 1'b0;
    handshake("bp");
    check("bp_not_taken", 64'(result), 64'h2345_6789);
    @(posedge clk);
    #1;
    check("bp_idle_hold", 64'(start_ready), 64'd1);

    // Reset in the middle of an ADD (after bits 0..9 have been processed)
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; alu_ctrl = 4'b0010; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_start_ready", 64'(start_ready), 64'd1);
    check("mrst_done_valid", 64'(done_valid), 64'd0);
    check("mrst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch("post_rst", 32'h1, 32'h1, 4'b0010);
    check("post_rst_const", 64'(result), 64'h2);
    handshake("post_rst");

    // Randomized operations, all 16 control codes reachable
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 4'($urandom_range(0, 15));
      if (n % 6 == 0) rb = ra;
      run_op("rand", ra, rb, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
